// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer between the time/alarm comparator and the buzzer driver.
// Arms, rings on match, runs snooze and ring-timeout intervals, and holds off re-trigger.
module alarm_ring_ctrl #(
    parameter int unsigned SNZ_SECS  = 300,
    parameter int unsigned RING_SECS = 600,
    parameter int unsigned MAX_SNZ   = 3,
    parameter int unsigned CNT_W     = 10
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       AlarmEn,
    input  logic       Match,
    input  logic       Tick,
    input  logic       SnoozeBtn,
    input  logic       StopBtn,
    output logic       Ringing,
    output logic       Snoozing,
    output logic       Buzzer,
    output logic [1:0] SnzCnt,
    output logic       DonePls
);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StRing,
        StSnooze,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] SnzLast  = CNT_W'(SNZ_SECS - 1);
    localparam logic [CNT_W-1:0] RingLast = CNT_W'(RING_SECS - 1);
    localparam logic [1:0]       MaxSnz   = 2'(MAX_SNZ);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       snz_cnt_q, snz_cnt_d;
    logic             phase_q, phase_d;
    logic             snz_btn_q, snz_btn_d;
    logic             stp_btn_q, stp_btn_d;
    logic             ringing_q, ringing_d;
    logic             snoozing_q, snoozing_d;
    logic             buzzer_q, buzzer_d;
    logic             done_pls_q, done_pls_d;
    logic             snz_e, stp_e;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snz_cnt_d = snz_cnt_q;
        phase_d   = phase_q;
        snz_btn_d = SnoozeBtn;
        stp_btn_d = StopBtn;
        snz_e     = SnoozeBtn & ~snz_btn_q;
        stp_e     = StopBtn & ~stp_btn_q;

        if (!AlarmEn) begin
            // Disabling the alarm aborts any activity, whatever the state.
            state_d   = StIdle;
            cnt_d     = '0;
            snz_cnt_d = '0;
            phase_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArmed;
                end
                StArmed: begin
                    if (Match) begin
                        state_d   = StRing;
                        cnt_d     = '0;
                        phase_d   = 1'b1;
                        snz_cnt_d = '0;
                    end
                end
                StRing: begin
                    if (stp_e) begin
                        state_d = StDone;
                    end else if (snz_e && (snz_cnt_q < MaxSnz)) begin
                        state_d   = StSnooze;
                        snz_cnt_d = snz_cnt_q + 2'd1;
                        cnt_d     = '0;
                    end else if (Tick) begin
                        // An exhausted snooze press falls through to normal timing.
                        phase_d = ~phase_q;
                        if (cnt_q == RingLast) begin
                            state_d = StDone;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StSnooze: begin
                    if (stp_e) begin
                        state_d = StDone;
                    end else if (Tick) begin
                        if (cnt_q == SnzLast) begin
                            state_d = StRing;
                            cnt_d   = '0;
                            phase_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StDone: begin
                    // Wait out the matching minute so the same alarm cannot retrigger.
                    if (!Match) begin
                        state_d   = StArmed;
                        snz_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        ringing_d  = (state_d == StRing);
        snoozing_d = (state_d == StSnooze);
        buzzer_d   = (state_d == StRing) & phase_d;
        done_pls_d = (state_d == StDone) & (state_q != StDone);
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            snz_cnt_q  <= '0;
            phase_q    <= 1'b0;
            snz_btn_q  <= 1'b0;
            stp_btn_q  <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            buzzer_q   <= 1'b0;
            done_pls_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            phase_q    <= phase_d;
            snz_btn_q  <= snz_btn_d;
            stp_btn_q  <= stp_btn_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
            buzzer_q   <= buzzer_d;
            done_pls_q <= done_pls_d;
        end
    end

    assign Ringing  = ringing_q;
    assign Snoozing = snoozing_q;
    assign Buzzer   = buzzer_q;
    assign SnzCnt   = snz_cnt_q;
    assign DonePls  = done_pls_q;

endmodule
